// File: rtl/aes_round_sched.sv
// aes_round_sched: sequencing controller for an iterative AES round datapath
//   (load, NR round strobes, round-key index / rcon / last-round flag).
// Latency: request accepted at edge T -> out_valid first high in cycle T+2+NR*DP_LAT.
// Backpressure: in_ready only while idle; the result is held until out_ready.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   block request handshake
//   out_valid/out_ready result handshake
//   ld_init             one-cycle strobe: datapath loads block ^ round key 0 (or NR)
//   round_en            one-cycle strobe: datapath state captures the round output
//   rnd_idx, rcon       round-key index and round constant for the key schedule
//   last_round          final round in progress/held, datapath skips MixColumns
//   busy                high while loading or running rounds
// Optional build macro AES_ROUND_SCHED_DECRYPT_EN adds input dec (inverse cipher
// ordering: key index runs NR..0, rcon forced to zero).
module aes_round_sched #(
  parameter int NR     = 10,
  parameter int DP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
`ifdef AES_ROUND_SCHED_DECRYPT_EN
  input  logic       dec,
`endif
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ld_init,
  output logic       round_en,
  output logic [3:0] rnd_idx,
  output logic       last_round,
  output logic [7:0] rcon,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Final value of the per-round wait counter and the final round index.
  localparam logic [2:0] LAST_CNT = 3'(DP_LAT - 1);
  localparam logic [3:0] NR_IDX   = 4'(NR);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] rnd_q;     // forward round number, 0..NR
  logic       dec_q;     // direction captured at acceptance
  logic       dec_in;

`ifdef AES_ROUND_SCHED_DECRYPT_EN
  assign dec_in = dec;
`else
  assign dec_in = 1'b0;
`endif

  // Single sequencing process. The handshake and strobe outputs are flops
  // loaded with their value for the state being entered, so nothing on the
  // outputs depends combinationally on in_valid or out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      rnd_q      <= 4'd0;
      dec_q      <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      ld_init    <= 1'b0;
      round_en   <= 1'b0;
      busy       <= 1'b0;
      last_round <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= LOAD;
            rnd_q    <= 4'd0;
            cnt      <= 3'd0;
            dec_q    <= dec_in;
            in_ready <= 1'b0;
            ld_init  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          state      <= RUN;
          rnd_q      <= 4'd1;
          cnt        <= 3'd0;
          ld_init    <= 1'b0;
          // With a one-cycle datapath the very first RUN cycle is a strobe.
          round_en   <= (LAST_CNT == 3'd0);
          last_round <= (NR_IDX == 4'd1);
        end

        RUN: begin
          if (cnt == LAST_CNT) begin
            cnt <= 3'd0;
            if (rnd_q == NR_IDX) begin
              state     <= HOLD;
              round_en  <= 1'b0;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              // last_round stays high through HOLD
            end else begin
              rnd_q      <= rnd_q + 4'd1;
              round_en   <= (LAST_CNT == 3'd0);
              last_round <= ((rnd_q + 4'd1) == NR_IDX);
            end
          end else begin
            cnt      <= cnt + 3'd1;
            round_en <= ((cnt + 3'd1) == LAST_CNT);
          end
        end

        HOLD: begin
          if (out_ready) begin
            state      <= IDLE;
            rnd_q      <= 4'd0;
            dec_q      <= 1'b0;
            out_valid  <= 1'b0;
            last_round <= 1'b0;
            in_ready   <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reported key index: forward count for encryption, mirrored for the
  // inverse cipher so the key schedule walks from the stored final key.
`ifdef AES_ROUND_SCHED_DECRYPT_EN
  assign rnd_idx = dec_q ? (NR_IDX - rnd_q) : rnd_q;
`else
  assign rnd_idx = rnd_q;
`endif

  // Round constant for the forward key expansion; zero outside rounds 1..10
  // and whenever the inverse ordering is in use.
  always_comb begin
    rcon = 8'h00;
    if (!dec_q) begin
      case (rnd_q)
        4'd1:    rcon = 8'h01;
        4'd2:    rcon = 8'h02;
        4'd3:    rcon = 8'h04;
        4'd4:    rcon = 8'h08;
        4'd5:    rcon = 8'h10;
        4'd6:    rcon = 8'h20;
        4'd7:    rcon = 8'h40;
        4'd8:    rcon = 8'h80;
        4'd9:    rcon = 8'h1B;
        4'd10:   rcon = 8'h36;
        default: rcon = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: three scheduler instances (NR/DP_LAT = 10/1, 10/3, 14/2)
// share one stimulus stream; a cycle-offset model predicts every output each
// cycle, and directed literal expectations pin latency, rcon and reset values.
module tb_aes_round_sched;

  localparam int NI = 3;
  localparam int NRS [NI] = '{10, 10, 14};
  localparam int LS  [NI] = '{1, 3, 2};
`ifdef AES_ROUND_SCHED_DECRYPT_EN
  localparam bit DEC_BUILD = 1'b1;
`else
  localparam bit DEC_BUILD = 1'b0;
`endif

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic dec;

  logic       in_ready_w   [NI];
  logic       out_valid_w  [NI];
  logic       ld_init_w    [NI];
  logic       round_en_w   [NI];
  logic [3:0] rnd_idx_w    [NI];
  logic       last_round_w [NI];
  logic [7:0] rcon_w       [NI];
  logic       busy_w       [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_round_sched #(.NR(10), .DP_LAT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef AES_ROUND_SCHED_DECRYPT_EN
    .dec(dec),
`endif
    .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .ld_init(ld_init_w[0]), .round_en(round_en_w[0]), .rnd_idx(rnd_idx_w[0]),
    .last_round(last_round_w[0]), .rcon(rcon_w[0]), .busy(busy_w[0])
  );

  aes_round_sched #(.NR(10), .DP_LAT(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef AES_ROUND_SCHED_DECRYPT_EN
    .dec(dec),
`endif
    .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .ld_init(ld_init_w[1]), .round_en(round_en_w[1]), .rnd_idx(rnd_idx_w[1]),
    .last_round(last_round_w[1]), .rcon(rcon_w[1]), .busy(busy_w[1])
  );

  aes_round_sched #(.NR(14), .DP_LAT(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef AES_ROUND_SCHED_DECRYPT_EN
    .dec(dec),
`endif
    .in_ready(in_ready_w[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .ld_init(ld_init_w[2]), .round_en(round_en_w[2]), .rnd_idx(rnd_idx_w[2]),
    .last_round(last_round_w[2]), .rcon(rcon_w[2]), .busy(busy_w[2])
  );

  // ---------------- behavioural model ----------------
  // Phase 0 idle, 1 active (m_t = cycles since acceptance, 1 = load cycle),
  // 2 result waiting for out_ready.
  int m_ph  [NI];
  int m_t   [NI];
  bit m_dec [NI];

  // rcon(r) = x^(r-1) in GF(2^8) modulo x^8+x^4+x^3+x+1, for r = 1..10.
  function automatic logic [7:0] gf_rcon(input int r);
    logic [7:0] v;
    if (r < 1 || r > 10) return 8'h00;
    v = 8'h01;
    for (int i = 1; i < r; i++) v = v[7] ? ((v << 1) ^ 8'h1B) : (v << 1);
    return v;
  endfunction

  function automatic logic [17:0] exp_vec(input int k);
    int nr, l, j, r;
    logic ir, ov, ld, re, bs, lr;
    logic [3:0] idx;
    logic [7:0] rc;
    nr = NRS[k]; l = LS[k];
    ir = 1'b0; ov = 1'b0; ld = 1'b0; re = 1'b0; bs = 1'b0; lr = 1'b0;
    r = 0; rc = 8'h00;
    case (m_ph[k])
      0: ir = 1'b1;
      1: begin
        bs = 1'b1;
        if (m_t[k] == 1) begin
          ld = 1'b1;
          r  = 0;
        end else begin
          j  = m_t[k] - 2;
          r  = j / l + 1;
          re = (j % l == l - 1);
        end
        lr = (r == nr);
        rc = gf_rcon(r);
      end
      default: begin
        ov = 1'b1;
        r  = nr;
        lr = 1'b1;
        rc = gf_rcon(nr);
      end
    endcase
    idx = 4'(r);
    if (m_dec[k] && m_ph[k] != 0) begin
      idx = 4'(nr - r);
      rc  = 8'h00;
    end
    return {ir, ov, ld, re, bs, lr, idx, rc};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_ph[k]  <= 0;
        m_t[k]   <= 0;
        m_dec[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        case (m_ph[k])
          0: if (in_valid) begin
            m_ph[k]  <= 1;
            m_t[k]   <= 1;
            m_dec[k] <= DEC_BUILD && dec;
          end
          1: if (m_t[k] == NRS[k] * LS[k] + 1) m_ph[k] <= 2;
             else m_t[k] <= m_t[k] + 1;
          default: if (out_ready) m_ph[k] <= 0;
        endcase
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        logic [17:0] act, expv;
        act  = {in_ready_w[k], out_valid_w[k], ld_init_w[k], round_en_w[k],
                busy_w[k], last_round_w[k], rnd_idx_w[k], rcon_w[k]};
        expv = exp_vec(k);
        n_tests++;
        if (act !== expv) begin
          n_fail++;
          $display("FAIL model_cmp inst%0d t=%0t: got %05h expected %05h (rdy,ov,ld,re,busy,last,idx,rcon)",
                   k, $time, act, expv);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  int first_ld [NI];
  int first_ov [NI];
  int first_re [NI];
  int first_lr [NI];
  int re_cnt   [NI];
  int re_idx   [NI][16];
  int re_rc    [NI][16];
  int a_ov [64];
  int a_idx[64];
  int a_re [64];
  int a_ld [64];
  int a_lr [64];
  int a_rdy[64];
  int p_bsy, p_re, p_rdy, p_idx, p_ov, p_lr;

  // Issues one request at offset 0 and records outputs for ncyc cycles.
  // out_ready is low for offsets below stall_until; in_valid is pulsed again
  // at pulse_at; reset is asserted mid-cycle at rst_at (ending the run).
  task automatic run_req(input int ncyc, input int stall_until, input int pulse_at,
                         input int rst_at);
    for (int k = 0; k < NI; k++) begin
      first_ld[k] = -1; first_ov[k] = -1; first_re[k] = -1; first_lr[k] = -1;
      re_cnt[k] = 0;
    end
    in_valid  = 1'b1;
    out_ready = (stall_until <= 0);
    for (int off = 0; off < ncyc; off++) begin
      for (int k = 0; k < NI; k++) begin
        if (ld_init_w[k] && first_ld[k] < 0) first_ld[k] = off;
        if (out_valid_w[k] && first_ov[k] < 0) first_ov[k] = off;
        if (last_round_w[k] && first_lr[k] < 0) first_lr[k] = off;
        if (round_en_w[k]) begin
          if (first_re[k] < 0) first_re[k] = off;
          if (re_cnt[k] < 16) begin
            re_idx[k][re_cnt[k]] = int'(rnd_idx_w[k]);
            re_rc[k][re_cnt[k]]  = int'(rcon_w[k]);
          end
          re_cnt[k]++;
        end
      end
      a_ov[off] = out_valid_w[0]; a_idx[off] = rnd_idx_w[0]; a_re[off] = round_en_w[0];
      a_ld[off] = ld_init_w[0];   a_lr[off]  = last_round_w[0]; a_rdy[off] = in_ready_w[0];
      if (off == rst_at) begin
        #2 rst = 1'b1;
        #1;
        p_bsy = busy_w[0]; p_re = round_en_w[0]; p_rdy = in_ready_w[0];
        p_idx = rnd_idx_w[0]; p_ov = out_valid_w[0]; p_lr = last_round_w[0];
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        return;
      end
      @(negedge clk);
      in_valid  = (off + 1 == pulse_at);
      out_ready = (off + 1 >= stall_until);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dec = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready_w[0], 1);
    chk("reset_out_valid", out_valid_w[0], 0);
    chk("reset_busy", busy_w[0], 0);
    chk("reset_rcon", rcon_w[0], 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Basic single request on all three configurations.
    run_req(42, 0, -1, -1);
    chk("lat1_ld_init_cycle", first_ld[0], 1);
    chk("lat1_first_round_en", first_re[0], 2);
    chk("lat1_out_valid_cycle", first_ov[0], 12);
    chk("lat1_last_round_cycle", first_lr[0], 11);
    chk("lat1_last_round_hold", a_lr[12], 1);
    chk("lat1_last_round_off", a_lr[13], 0);
    chk("lat1_in_ready_back", a_rdy[13], 1);
    chk("lat1_in_ready_hold", a_rdy[12], 0);
    chk("lat1_round_count", re_cnt[0], 10);
    for (int i = 0; i < 10; i++) chk($sformatf("lat1_idx_round%0d", i + 1), re_idx[0][i], i + 1);
    chk("rcon_r1", re_rc[0][0], 8'h01);
    chk("rcon_r5", re_rc[0][4], 8'h10);
    chk("rcon_r8", re_rc[0][7], 8'h80);
    chk("rcon_r9", re_rc[0][8], 8'h1B);
    chk("rcon_r10", re_rc[0][9], 8'h36);
    chk("lat3_first_round_en", first_re[1], 4);
    chk("lat3_out_valid_cycle", first_ov[1], 32);
    chk("lat3_round_count", re_cnt[1], 10);
    chk("nr14_out_valid_cycle", first_ov[2], 30);
    chk("nr14_round_count", re_cnt[2], 14);
    for (int i = 10; i < 14; i++) chk($sformatf("nr14_rcon_r%0d", i + 1), re_rc[2][i], 8'h00);

    // Result held under out_ready low; in_valid pulse during RUN is ignored.
    run_req(42, 17, 5, -1);
    for (int c = 12; c <= 16; c++) begin
      chk($sformatf("stall_out_valid_c%0d", c), a_ov[c], 1);
      chk($sformatf("stall_idx_c%0d", c), a_idx[c], 10);
      chk($sformatf("stall_no_strobe_c%0d", c), a_re[c] | a_ld[c], 0);
    end
    chk("stall_accept_cycle_ov", a_ov[17], 1);
    chk("stall_exit_in_ready", a_rdy[18], 1);
    chk("stall_exit_out_valid", a_ov[18], 0);
    chk("pulse_ignored_no_load", a_ld[6], 0);

    // Asynchronous reset in round 5.
    run_req(20, 0, -1, 6);
    chk("prerst_idx_round5", a_idx[6], 5);
    chk("prerst_round_en", a_re[6], 1);
    chk("rst_busy", p_bsy, 0);
    chk("rst_round_en", p_re, 0);
    chk("rst_in_ready", p_rdy, 1);
    chk("rst_rnd_idx", p_idx, 0);
    chk("rst_out_valid", p_ov, 0);
    chk("rst_last_round", p_lr, 0);
    run_req(42, 0, -1, -1);
    chk("postrst_out_valid_cycle", first_ov[0], 12);
    chk("postrst_lat3_out_valid", first_ov[1], 32);
    chk("postrst_round_count", re_cnt[0], 10);

`ifdef AES_ROUND_SCHED_DECRYPT_EN
    dec = 1'b1;
    run_req(42, 0, -1, -1);
    dec = 1'b0;
    chk("dec_ld_init_cycle", first_ld[0], 1);
    chk("dec_ld_idx", a_idx[1], 10);
    chk("dec_round_count", re_cnt[0], 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("dec_idx_round%0d", i + 1), re_idx[0][i], 9 - i);
      chk($sformatf("dec_rcon_round%0d", i + 1), re_rc[0][i], 0);
    end
    chk("dec_last_round_cycle", first_lr[0], 11);
    chk("dec_last_round_idx", a_idx[11], 0);
    chk("dec_out_valid_cycle", first_ov[0], 12);
    // A following encryption must revert to the forward ordering.
    run_req(42, 0, -1, -1);
    chk("enc_after_dec_idx_r1", re_idx[0][0], 1);
    chk("enc_after_dec_rcon_r10", re_rc[0][9], 8'h36);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
